puf_response_packer: RTL
========================

Name: puf_response_packer

Overview:
- Upstream stage of the UART transmit path.
- Collects single-bit PUF response samples into a WORD_WIDTH-bit word.
- Presents completed words on a valid/ready interface that feeds the UART serializer.
- A one-word hold buffer lets accumulation continue while the serializer is busy. Overflow is flagged, never silently lost.

Parameters:
WORD_WIDTH, 63, bits per packed word; matches the serializer input width.
CNT_WIDTH, 6, width of the bit counter; must satisfy 2**CNT_WIDTH > WORD_WIDTH.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
bit_in  input  1  PUF response bit
bit_valid  input  1  bit_in is sampled this cycle
flush  input  1  emit the current partial word (zero-padded)
output_data  output  WORD_WIDTH  packed word to the serializer
output_valid  output  1  output_data holds an unconsumed word
output_ready  input  1  serializer accepts output_data this cycle
overflow  output  1  sticky: at least one bit was dropped
clear_overflow  input  1  clears overflow
bit_count  output  CNT_WIDTH  bits currently in the accumulator

Behaviour:
- Reset (rst=1 at a clock edge):
  - output_valid=0, output_data=0, overflow=0, bit_count=0.
  - Accumulator cleared; state=ACCUM.
  - Reset mid-word or mid-handshake discards all partial and pending data.
- Packing:
  - On accept, acc <= {acc[WORD_WIDTH-2:0], bit_in} and cnt <= cnt+1.
  - The first bit of a word ends at bit WORD_WIDTH-1; the last bit ends at bit 0.
  - A flushed partial word is right-aligned: the first bit sits at bit cnt-1 and upper bits are 0.
- Slot free: free = !output_valid || output_ready.
- Output register rules:
  - Handshake completes when output_valid && output_ready; output_valid drops next cycle unless a new word is loaded in the same cycle.
  - output_data is held stable while output_valid && !output_ready.
- State ACCUM:
  - bit_valid is always accepted.
  - Word completes when (bit_valid && cnt==WORD_WIDTH-1), or when (flush && cnt_after>0), where cnt_after includes a same-cycle accepted bit.
  - On completion with free: output_data <= word, output_valid <= 1, acc/cnt <= 0, stay in ACCUM. This allows back-to-back words with no bubble.
  - On completion with !free: the word stays in acc, cnt holds its length, go to HOLD.
  - flush with cnt_after==0: no effect.
- State HOLD:
  - bit_valid is dropped and overflow <= 1.
  - flush is ignored.
  - When free: output_data <= acc, output_valid <= 1, acc/cnt <= 0, go to ACCUM. The first bit accepted after that is the cycle after the transfer.
- Latency: output_valid rises the cycle after the completing bit or flush is accepted, provided the slot is free.
- Throughput: with output_ready held high and bit_valid high every cycle, one word is emitted every WORD_WIDTH cycles and no bits are dropped.
- overflow:
  - Set by any dropped bit; cleared by clear_overflow.
  - If set and clear occur in the same cycle, set wins.
- bit_count equals cnt. It reads WORD_WIDTH while in HOLD after a full word, and reads the partial length while in HOLD after a flush.

Test Plan:
- Reset, then 63 bits alternating 1,0,… starting with 1, with output_ready=1 -> output_valid one cycle after the 63rd bit, output_data=63'h5555_5555_5555_5555, bit_count returns to 0, overflow=0.
- 5 bits 1,0,1,1,1 then flush -> output_data=63'h17, output_valid=1 next cycle; flush with bit_count=0 -> no output_valid.
- output_ready=0, stream 63+63 bits continuously -> first word held stable in output_data; second word enters HOLD with bit_count=63; bit 127 is dropped and overflow=1. Then output_ready=1 for one cycle -> second word loaded the next cycle with no corruption.
- Back-to-back: output_ready=1, bit_valid=1 for 189 cycles -> exactly 3 output_valid pulses spaced 63 cycles apart, zero drops.
- Raise overflow, then assert clear_overflow while a bit is dropped -> overflow stays 1. Clear on a later cycle with no drop -> overflow=0.
- Assert rst with 40 bits accumulated and a word pending in HOLD -> next cycle output_valid=0, bit_count=0, overflow=0; the next 63 bits form a fresh word.

Source files
------------

// File: rtl/puf_response_packer.sv
// Packs single-bit PUF response samples into WORD_WIDTH-bit words for the
// UART serializer. Includes a one-word hold buffer so accumulation can keep
// going while the serializer is stalled. Any bit that cannot be stored is
// reported through a sticky overflow flag.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   bit_in         PUF response bit
//   bit_valid      bit_in is sampled this cycle
//   flush          emit the current partial word, right-aligned and zero-padded
//   output_data    packed word presented to the serializer
//   output_valid   output_data holds an unconsumed word
//   output_ready   serializer accepts output_data this cycle
//   overflow       sticky: at least one bit was dropped
//   clear_overflow clears overflow (a same-cycle drop takes priority)
//   bit_count      number of bits currently held in the accumulator
module puf_response_packer #(
  parameter int unsigned WORD_WIDTH = 63,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  input  logic                  flush,
  output logic [WORD_WIDTH-1:0] output_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic                  overflow,
  input  logic                  clear_overflow,
  output logic [CNT_WIDTH-1:0]  bit_count
);

  // ACCUM: collecting bits. HOLD: acc holds a finished word waiting for the
  // output slot; incoming bits are dropped.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(WORD_WIDTH - 1);

  state_t                 state;
  logic [WORD_WIDTH-1:0]  acc;
  logic [CNT_WIDTH-1:0]   cnt;

  logic                   free_c;
  logic                   accept_c;
  logic                   drop_c;
  logic                   complete_c;
  logic [WORD_WIDTH-1:0]  acc_next_c;
  logic [CNT_WIDTH-1:0]   cnt_after_c;

  // Slot availability and the accumulator value including this cycle's bit.
  always_comb begin
    free_c      = !output_valid || output_ready;
    accept_c    = (state == ACCUM) && bit_valid;
    drop_c      = (state == HOLD) && bit_valid;
    acc_next_c  = accept_c ? {acc[WORD_WIDTH-2:0], bit_in} : acc;
    cnt_after_c = accept_c ? cnt + CNT_WIDTH'(1) : cnt;
    // A full word, or a flush that would emit at least one bit.
    complete_c  = (state == ACCUM) &&
                  ((accept_c && (cnt == LAST_IDX)) ||
                   (flush && (cnt_after_c != '0)));
  end

  // State, accumulator, output register and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUM;
      acc          <= '0;
      cnt          <= '0;
      output_data  <= '0;
      output_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      // Completed handshake empties the slot unless a load below refills it.
      if (output_valid && output_ready) begin
        output_valid <= 1'b0;
      end

      // Set beats clear when both happen in the same cycle.
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end

      case (state)
        ACCUM: begin
          if (complete_c && free_c) begin
            output_data  <= acc_next_c;
            output_valid <= 1'b1;
            acc          <= '0;
            cnt          <= '0;
          end else begin
            // Word stays in acc with its length when the slot is busy.
            acc <= acc_next_c;
            cnt <= cnt_after_c;
            if (complete_c) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (free_c) begin
            output_data  <= acc;
            output_valid <= 1'b1;
            acc          <= '0;
            cnt          <= '0;
            state        <= ACCUM;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

  assign bit_count = cnt;

endmodule
